// File: rtl/pll_ctrl.sv
// pll_ctrl: bring-up and supervision controller for the alta_pllx PLL wrapper.
// Runs on the PLL reference clock. It sequences power-up, reset and lock
// acquisition, then qualifies lock stability before enabling the requested
// output clocks. Lock loss is retried; when the retries run out, the block
// latches a fault.
//
// Ports
//   clkin      reference clock (same net as the PLL clkin), only clock here
//   resetn     asynchronous active-low reset
//   en         controller enable, level sensitive
//   relock     single-cycle request to re-run reset/lock while in RUN
//   out_mask   requested output enables, bit n -> clkoutNen
//   lock       PLL lock, asynchronous, synchronized internally
//   pll_en     -> PLL pllen
//   pll_resetn -> PLL resetn
//   clkout_en  -> PLL clkout0en..clkout3en
//   ready      high only in RUN
//   fault      high only in FAULT
//   retries    consecutive failed-attempt count
module pll_ctrl #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clkin,
  input  logic       resetn,
  input  logic       en,
  input  logic       relock,
  input  logic [3:0] out_mask,
  input  logic       lock,
  output logic       pll_en,
  output logic       pll_resetn,
  output logic [3:0] clkout_en,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retries
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_ALL = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CW_RAW  = $clog2(MAX_ALL + 1);
  localparam int unsigned CNT_W   = (CW_RAW > 12) ? CW_RAW : 12;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_OFF,
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [1:0]       sync_q;
  logic             lock_s;
  logic             fail;
  logic [3:0]       retries_nxt;

  assign lock_s = sync_q[1];

  // Next-state logic. A failed attempt is an event rather than a state: it
  // bumps the retry count and redirects to RESET or FAULT on the same edge.
  always_comb begin
    state_nxt   = state_q;
    retries_nxt = retries;
    fail        = 1'b0;

    unique case (state_q)
      S_OFF: begin
        if (en) state_nxt = S_RESET;
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (cnt_q == TO_LAST) fail = 1'b1;
        else if (lock_s)      state_nxt = S_STABLE;
      end
      S_STABLE: begin
        if (!lock_s) begin
          fail = 1'b1;
        end else if (cnt_q == STB_LAST) begin
          state_nxt   = S_RUN;
          retries_nxt = '0;
        end
      end
      S_RUN: begin
        if (!lock_s)     fail = 1'b1;
        else if (relock) state_nxt = S_RESET;
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_OFF;
      end
    endcase

    if (fail) begin
      retries_nxt = retries + 4'd1;
      state_nxt   = (retries_nxt == RETRY_LIMIT) ? S_FAULT : S_RESET;
    end

    // Disable overrides everything, including a simultaneous failure.
    if (!en) begin
      state_nxt   = S_OFF;
      retries_nxt = '0;
    end
  end

  // The counter only runs in timed states; it clears on every state change.
  always_comb begin
    cnt_nxt = cnt_q;
    if (state_nxt != state_q) begin
      cnt_nxt = '0;
    end else if (state_q inside {S_RESET, S_WAIT_LOCK, S_STABLE}) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      state_q <= S_OFF;
      cnt_q   <= '0;
      retries <= '0;
    end else begin
      sync_q  <= {sync_q[0], lock};
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      retries <= retries_nxt;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge
  // as the state register.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      pll_en     <= 1'b0;
      pll_resetn <= 1'b0;
      clkout_en  <= '0;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pll_en     <= state_nxt inside {S_RESET, S_WAIT_LOCK, S_STABLE, S_RUN};
      pll_resetn <= state_nxt inside {S_WAIT_LOCK, S_STABLE, S_RUN};
      clkout_en  <= (state_nxt == S_RUN) ? out_mask : '0;
      ready      <= (state_nxt == S_RUN);
      fault      <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_ctrl.sv
// Self-checking bench for pll_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRY=2. Edge e=0 is the first edge that samples en=1.
// Expected output vectors {pll_en,pll_resetn,clkout_en,ready,fault,retries}
// are queued per edge and popped when that edge has been sampled.
module tb_pll_ctrl;

  logic       clkin = 1'b0;
  logic       resetn;
  logic       en;
  logic       relock;
  logic [3:0] out_mask;
  logic       lock;
  logic       pll_en;
  logic       pll_resetn;
  logic [3:0] clkout_en;
  logic       ready;
  logic       fault;
  logic [3:0] retries;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          edge_n;
    logic [11:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  pll_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) dut (
    .clkin     (clkin),
    .resetn    (resetn),
    .en        (en),
    .relock    (relock),
    .out_mask  (out_mask),
    .lock      (lock),
    .pll_en    (pll_en),
    .pll_resetn(pll_resetn),
    .clkout_en (clkout_en),
    .ready     (ready),
    .fault     (fault),
    .retries   (retries)
  );

  always #5 clkin = ~clkin;

  function automatic logic [11:0] outv();
    return {pll_en, pll_resetn, clkout_en, ready, fault, retries};
  endfunction

  function automatic logic [11:0] xv(logic pe, logic pr, logic [3:0] ce,
                                     logic rdy, logic flt, logic [3:0] rt);
    return {pe, pr, ce, rdy, flt, rt};
  endfunction

  // Expected vectors for each controller phase.
  function automatic logic [11:0] v_off();             return xv(0, 0, 4'h0, 0, 0, 4'h0); endfunction
  function automatic logic [11:0] v_rst(int rt);       return xv(1, 0, 4'h0, 0, 0, 4'(rt)); endfunction
  function automatic logic [11:0] v_wl(int rt);        return xv(1, 1, 4'h0, 0, 0, 4'(rt)); endfunction
  function automatic logic [11:0] v_run(logic [3:0] m); return xv(1, 1, m, 1, 0, 4'h0); endfunction
  function automatic logic [11:0] v_fault(int rt);     return xv(0, 0, 4'h0, 0, 1, 4'(rt)); endfunction

  function automatic void expect_at(int e, logic [11:0] v, string n);
    exp_t x;
    x.edge_n = e;
    x.v      = v;
    x.name   = n;
    exp_q.push_back(x);
  endfunction

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic idle();
    en       = 1'b0;
    relock   = 1'b0;
    lock     = 1'b0;
    out_mask = 4'h0;
    repeat (4) step();
    exp_q.delete();
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    en       = 1'b0;
    relock   = 1'b0;
    lock     = 1'b0;
    out_mask = 4'hF;
    repeat (2) step();
    checks++;
    if (outv() !== 12'h000) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", outv(), 12'h000);
    end
    en = 1'b1;
    lock = 1'b1;
    step();
    checks++;
    if (outv() !== 12'h000) begin
      failures++;
      $display("FAIL reset_held_en got=%h exp=%h", outv(), 12'h000);
    end
    en = 1'b0;
    resetn = 1'b1;
    repeat (2) step();
    checks++;
    if (outv() !== v_off()) begin
      failures++;
      $display("FAIL off_after_release got=%h exp=%h", outv(), v_off());
    end
  endtask

  task automatic test_bringup();
    exp_t x;
    idle();
    out_mask = 4'b0011;
    expect_at(0,  v_rst(0),        "bringup_reset_e0");
    expect_at(3,  v_rst(0),        "bringup_reset_e3");
    expect_at(4,  v_wl(0),         "bringup_resetn_rise");
    expect_at(15, v_wl(0),         "bringup_not_ready_e15");
    expect_at(16, v_run(4'b0011),  "bringup_run_e16");
    expect_at(17, v_run(4'b0011),  "bringup_run_e17");
    for (int e = 0; e < 18; e++) begin
      if (e == 0) en = 1'b1;
      if (e == 6) lock = 1'b1;
      step();
      while (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
        x = exp_q.pop_front();
        checks++;
        if (outv() !== x.v) begin
          failures++;
          $display("FAIL %s edge=%0d got=%h exp=%h", x.name, e, outv(), x.v);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL bringup_unconsumed got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_timeout_fault();
    exp_t x;
    idle();
    out_mask = 4'b1111;
    expect_at(0,  v_rst(0),   "timeout_reset_e0");
    expect_at(4,  v_wl(0),    "timeout_wait_e4");
    expect_at(23, v_wl(0),    "timeout_last_wait_e23");
    expect_at(24, v_rst(1),   "timeout_retry1_e24");
    expect_at(28, v_wl(1),    "timeout_wait2_e28");
    expect_at(47, v_wl(1),    "timeout_last_wait2_e47");
    expect_at(48, v_fault(2), "timeout_fault_e48");
    expect_at(60, v_fault(2), "timeout_fault_held");
    expect_at(61, v_off(),    "fault_cleared_by_en");
    for (int e = 0; e < 62; e++) begin
      if (e == 0)  en = 1'b1;
      if (e == 61) en = 1'b0;
      step();
      while (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
        x = exp_q.pop_front();
        checks++;
        if (outv() !== x.v) begin
          failures++;
          $display("FAIL %s edge=%0d got=%h exp=%h", x.name, e, outv(), x.v);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL timeout_unconsumed got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_glitch_stable();
    exp_t x;
    idle();
    out_mask = 4'b0101;
    expect_at(8,  v_wl(0),        "glitch_stable_e8");
    expect_at(11, v_wl(0),        "glitch_stable_e11");
    expect_at(12, v_rst(1),       "glitch_fail_e12");
    expect_at(15, v_rst(1),       "glitch_reset_e15");
    expect_at(16, v_wl(1),        "glitch_wait_e16");
    expect_at(20, v_wl(1),        "glitch_stable2_e20");
    expect_at(24, v_wl(1),        "glitch_stable2_e24");
    expect_at(25, v_run(4'b0101), "glitch_run_e25");
    for (int e = 0; e < 27; e++) begin
      if (e == 0)  en = 1'b1;
      if (e == 6)  lock = 1'b1;
      if (e == 10) lock = 1'b0;
      if (e == 12) lock = 1'b1;
      step();
      while (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
        x = exp_q.pop_front();
        checks++;
        if (outv() !== x.v) begin
          failures++;
          $display("FAIL %s edge=%0d got=%h exp=%h", x.name, e, outv(), x.v);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL glitch_unconsumed got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_loss_relock();
    exp_t x;
    idle();
    out_mask = 4'b1111;
    expect_at(16, v_run(4'b1111), "loss_run_e16");
    expect_at(21, v_run(4'b1111), "loss_still_run_e21");
    expect_at(22, v_rst(1),       "loss_drop_e22");
    expect_at(25, v_rst(1),       "loss_reset_e25");
    expect_at(26, v_wl(1),        "loss_wait_e26");
    expect_at(34, v_wl(1),        "loss_stable_e34");
    expect_at(35, v_run(4'b1111), "loss_rerun_e35");
    expect_at(38, v_rst(0),       "relock_reset_e38");
    expect_at(42, v_wl(0),        "relock_wait_e42");
    expect_at(46, v_wl(0),        "relock_ignored_stable");
    expect_at(51, v_run(4'b1111), "relock_run_e51");
    for (int e = 0; e < 52; e++) begin
      if (e == 0)  en = 1'b1;
      if (e == 6)  lock = 1'b1;
      if (e == 20) lock = 1'b0;
      if (e == 23) lock = 1'b1;
      if (e == 38) relock = 1'b1;
      if (e == 39) relock = 1'b0;
      if (e == 45) relock = 1'b1;
      if (e == 46) relock = 1'b0;
      step();
      while (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
        x = exp_q.pop_front();
        checks++;
        if (outv() !== x.v) begin
          failures++;
          $display("FAIL %s edge=%0d got=%h exp=%h", x.name, e, outv(), x.v);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL loss_unconsumed got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_mask_priority();
    exp_t x;
    idle();
    out_mask = 4'b0011;
    expect_at(16, v_run(4'b0011), "mask_run_e16");
    expect_at(17, v_run(4'b0011), "mask_before_change");
    expect_at(18, v_run(4'b1000), "mask_after_change");
    expect_at(19, v_run(4'b1000), "mask_held");
    expect_at(20, v_off(),        "en_over_relock");
    expect_at(21, v_off(),        "off_held");
    for (int e = 0; e < 22; e++) begin
      if (e == 0)  en = 1'b1;
      if (e == 6)  lock = 1'b1;
      if (e == 18) out_mask = 4'b1000;
      if (e == 20) begin
        en     = 1'b0;
        relock = 1'b1;
      end
      if (e == 21) relock = 1'b0;
      step();
      while (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
        x = exp_q.pop_front();
        checks++;
        if (outv() !== x.v) begin
          failures++;
          $display("FAIL %s edge=%0d got=%h exp=%h", x.name, e, outv(), x.v);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL mask_unconsumed got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    exp_t x;
    idle();
    out_mask = 4'b0110;
    expect_at(16, v_run(4'b0110), "areset_run_before");
    for (int e = 0; e < 18; e++) begin
      if (e == 0) en = 1'b1;
      if (e == 6) lock = 1'b1;
      step();
      while (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
        x = exp_q.pop_front();
        checks++;
        if (outv() !== x.v) begin
          failures++;
          $display("FAIL %s edge=%0d got=%h exp=%h", x.name, e, outv(), x.v);
        end
      end
    end
    #3;
    resetn = 1'b0;
    lock   = 1'b0;
    #1;
    checks++;
    if (outv() !== 12'h000) begin
      failures++;
      $display("FAIL areset_immediate got=%h exp=%h", outv(), 12'h000);
    end
    step();
    checks++;
    if (outv() !== 12'h000) begin
      failures++;
      $display("FAIL areset_held got=%h exp=%h", outv(), 12'h000);
    end
    resetn = 1'b1;
    expect_at(0,  v_rst(0),       "areset_rerun_reset_e0");
    expect_at(4,  v_wl(0),        "areset_rerun_wait_e4");
    expect_at(15, v_wl(0),        "areset_rerun_e15");
    expect_at(16, v_run(4'b0110), "areset_rerun_run_e16");
    for (int e = 0; e < 18; e++) begin
      if (e == 6) lock = 1'b1;
      step();
      while (exp_q.size() > 0 && exp_q[0].edge_n == e) begin
        x = exp_q.pop_front();
        checks++;
        if (outv() !== x.v) begin
          failures++;
          $display("FAIL %s edge=%0d got=%h exp=%h", x.name, e, outv(), x.v);
        end
      end
    end
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL areset_unconsumed got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_bringup();
    test_timeout_fault();
    test_glitch_stable();
    test_loss_relock();
    test_mask_priority();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_ctrl.md
# pll_ctrl

PLL bring-up and supervision controller for the `alta_pllx` PLL wrapper. It drives the PLL's `pllen`, `resetn` and `clkout0en`..`clkout3en` inputs and consumes its `lock` output. It sequences power-up, lock acquisition and a lock-stability qualification, then enables the requested output clocks. It recovers from lock loss by retrying, up to a bounded count, and enters a latched fault state when retries are exhausted. It runs on the PLL reference clock, so it never depends on a PLL output.

## Interface
- `RST_CYCLES`, 16: cycles the PLL is held in reset (`pll_resetn`=0) with `pll_en`=1.
- `LOCK_TIMEOUT`, 4096: maximum cycles to wait for synchronized lock after reset release.
- `STABLE_CYCLES`, 256: consecutive cycles synchronized lock must stay high before outputs are enabled.
- `MAX_RETRY`, 3: consecutive failed attempts before FAULT (1..15).
- `clkin` in 1: reference clock, the same net as the PLL `clkin`. This is the block's only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `en` in 1: controller enable. Level-sensitive and synchronous.
- `relock` in 1: single-cycle request to re-run the reset/lock sequence.
- `out_mask` in 4: requested output enables, bit n maps to `clkoutNen`.
- `lock` in 1: PLL lock. Asynchronous to `clkin`; it is synchronized internally.
- `pll_en` out 1: drives PLL `pllen`.
- `pll_resetn` out 1: drives PLL `resetn`.
- `clkout_en` out 4: drives PLL `clkout0en`..`clkout3en`.
- `ready` out 1: high only in RUN.
- `fault` out 1: high only in FAULT.
- `retries` out 4: consecutive failed-attempt count.

## Operation
- `lock` passes through a 2-flop synchronizer to give `lock_s`. All decisions use `lock_s`.
- One cycle counter, 12 bits minimum and sized to the largest parameter. It clears on every state change.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- Reset values: state OFF, `pll_en`=0, `pll_resetn`=0, `clkout_en`=0, `ready`=0, `fault`=0, `retries`=0, counter=0, synchronizer=0.
- OFF: `pll_en`=0, `pll_resetn`=0. If `en`=1, go to RESET.
- RESET: `pll_en`=1, `pll_resetn`=0. After RST_CYCLES cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK: `pll_en`=1, `pll_resetn`=1.
  - `lock_s`=1 goes to STABLE.
  - Counter reaching LOCK_TIMEOUT-1 is a FAIL.
- STABLE: same PLL drive as WAIT_LOCK.
  - `lock_s`=0 is a FAIL.
  - After STABLE_CYCLES consecutive cycles with `lock_s`=1, go to RUN and clear `retries`.
- RUN: `clkout_en`=`out_mask` (each mask change appears one cycle later), `ready`=1.
  - `lock_s`=0 is a FAIL, and `clkout_en` drops to 0 on that same edge.
  - `relock`=1 goes to RESET without incrementing `retries`.
- FAIL: `retries` increments. If the new value equals MAX_RETRY, go to FAULT; otherwise go to RESET.
- FAULT: `pll_en`=0, `pll_resetn`=0, `clkout_en`=0, `fault`=1. Stays here while `en`=1.
- Priority, highest first:
  1. `en`=0 in any state goes to OFF next edge; this clears `retries` and `fault`.
  2. FAIL.
  3. `relock`.
  4. Normal transitions.
- `relock` is ignored outside RUN.
- `clkout_en` is 0 in every state except RUN.
- Async reset asserted mid-operation forces reset values immediately. It is not latched; after release the block starts from OFF.

## Timing
- `en` rising and sampled at edge k: RESET, `pll_en`=1 from edge k.
- `pll_resetn` rises at edge k+RST_CYCLES.
- `lock` rising before edge j gives `lock_s`=1 after edge j+1; STABLE is entered at edge j+2.
- RUN, `ready`=1 and `clkout_en`=`out_mask` all take effect at edge j+2+STABLE_CYCLES.
- Lock-loss reaction latency is 3 edges from `lock` falling to `clkout_en`=0: 2 synchronizer edges plus 1 state edge.
- A single-cycle `lock` glitch shorter than one `clkin` period may be missed. Any glitch seen on `lock_s` counts as a FAIL.

## Test plan
Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.

- **Normal bring-up.** `en`=1 at edge 0, `lock` high from edge 6, `out_mask`=4'b0011 → `pll_resetn` rises at edge 4, `ready`=1 and `clkout_en`=0011 at edge 16, `retries`=0.
- **Timeout to fault.** `lock` held 0 → two WAIT_LOCK timeouts, `retries` goes 1 then 2, `fault`=1, `pll_en`=0. Dropping `en`=0 → OFF next edge, `fault`=0, `retries`=0.
- **Glitch in STABLE.** `lock` drops for 2 cycles during STABLE → `retries`=1, RESET re-entered, `clkout_en` stays 0 throughout. A second clean lock → RUN and `retries`=0.
- **Loss in RUN.** `lock` falls in RUN → `clkout_en`=0 and `ready`=0 three edges later. `relock` pulse in RUN → RESET with `retries` unchanged.
- **Mask and enable priority.** Change `out_mask` to 1000 in RUN → `clkout_en`=1000 next edge. `en`=0 and `relock`=1 on the same cycle → OFF.
- **Async reset mid-RUN.** `resetn` low mid-cycle → all outputs 0 immediately. After release, with `en` still 1 → full sequence repeats from edge 0 timing.
